// File: rtl/apb_rr_master10.sv
// Two-requester APB master: round-robin arbitration in IDLE, then an APB SETUP/ACCESS
// transfer for the granted requester, finished by a one-cycle done pulse or a wait-state timeout.
module apb_rr_master10 #(
   parameter int PADDR_WIDTH10  = 32,
   parameter int PWDATA_WIDTH10 = 32,
   parameter int PRDATA_WIDTH10 = 32,
   parameter int TIMEOUT10      = 16
) (
   input  logic                        pclock10,
   input  logic                        preset10,
   input  logic [1:0]                  req10,
   input  logic [2*PADDR_WIDTH10-1:0]  addr10,
   input  logic [1:0]                  write10,
   input  logic [2*PWDATA_WIDTH10-1:0] wdata10,
   output logic [1:0]                  done10,
   output logic [PRDATA_WIDTH10-1:0]   rdata10,
   output logic                        err10,
   output logic [PADDR_WIDTH10-1:0]    paddr10,
   output logic                        prwd10,
   output logic [PWDATA_WIDTH10-1:0]   pwdata10,
   output logic [15:0]                 psel10,
   output logic                        penable10,
   input  logic                        pready10,
   input  logic [PRDATA_WIDTH10-1:0]   prdata10,
   input  logic                        pslverr10,
   output logic [1:0]                  dbg_state10
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETUP  = 2'd1;
   localparam logic [1:0] ST_ACCESS = 2'd2;
   localparam logic [7:0] TO_LAST   = 8'(TIMEOUT10 - 1);

   logic [1:0]                  state_q, state_d;
   logic                        gnt_q, gnt_d;
   logic                        prio_q, prio_d;
   logic [7:0]                  wait_q, wait_d;
   logic [PADDR_WIDTH10-1:0]    paddr_q, paddr_d;
   logic                        prwd_q, prwd_d;
   logic [PWDATA_WIDTH10-1:0]   pwdata_q, pwdata_d;
   logic [15:0]                 psel_q, psel_d;
   logic                        penable_q, penable_d;
   logic [1:0]                  done_q, done_d;
   logic [PRDATA_WIDTH10-1:0]   rdata_q, rdata_d;
   logic                        err_q, err_d;

   logic [1:0]                  req_eff;
   logic                        grant_idx;
   logic [PADDR_WIDTH10-1:0]    sel_addr;
   logic                        finish;

   // Handshake: a requester raises req10[i] with stable addr/write/wdata and keeps them until
   // done10[i] pulses; the pulse masks that requester for one arbitration so the other gets a turn.
   always_comb begin
      req_eff   = req10 & ~done_q;
      grant_idx = (req_eff == 2'b11) ? prio_q : (req_eff[1] & ~req_eff[0]);
      sel_addr  = grant_idx ? addr10[2*PADDR_WIDTH10-1 -: PADDR_WIDTH10]
                            : addr10[PADDR_WIDTH10-1:0];
   end

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      prio_d    = prio_q;
      wait_d    = wait_q;
      paddr_d   = paddr_q;
      prwd_d    = prwd_q;
      pwdata_d  = pwdata_q;
      psel_d    = psel_q;
      penable_d = penable_q;
      done_d    = 2'b00;
      rdata_d   = rdata_q;
      err_d     = err_q;
      finish    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            psel_d    = 16'h0000;
            penable_d = 1'b0;
            if (req_eff != 2'b00) begin
               gnt_d    = grant_idx;
               prio_d   = ~grant_idx;
               paddr_d  = sel_addr;
               prwd_d   = write10[grant_idx];
               pwdata_d = grant_idx ? wdata10[2*PWDATA_WIDTH10-1 -: PWDATA_WIDTH10]
                                    : wdata10[PWDATA_WIDTH10-1:0];
               psel_d   = 16'(1) << sel_addr[15:12];
               state_d  = ST_SETUP;
            end
         end
         ST_SETUP: begin
            penable_d = 1'b1;
            wait_d    = 8'd0;
            state_d   = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (pready10) begin
               finish = 1'b1;
               err_d  = pslverr10;
               if (!prwd_q) rdata_d = prdata10;
            end else if (wait_q == TO_LAST) begin
               // Slave never answered: abort with an error, read data left untouched.
               finish = 1'b1;
               err_d  = 1'b1;
            end else begin
               wait_d = wait_q + 8'd1;
            end
            if (finish) begin
               psel_d         = 16'h0000;
               penable_d      = 1'b0;
               done_d[gnt_q]  = 1'b1;
               state_d        = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge pclock10 or negedge preset10) begin
      if (!preset10) begin
         state_q   <= ST_IDLE;
         gnt_q     <= 1'b0;
         prio_q    <= 1'b0;
         wait_q    <= 8'd0;
         paddr_q   <= '0;
         prwd_q    <= 1'b0;
         pwdata_q  <= '0;
         psel_q    <= 16'h0000;
         penable_q <= 1'b0;
         done_q    <= 2'b00;
         rdata_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         prio_q    <= prio_d;
         wait_q    <= wait_d;
         paddr_q   <= paddr_d;
         prwd_q    <= prwd_d;
         pwdata_q  <= pwdata_d;
         psel_q    <= psel_d;
         penable_q <= penable_d;
         done_q    <= done_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
      end
   end

   assign done10      = done_q;
   assign rdata10     = rdata_q;
   assign err10       = err_q;
   assign paddr10     = paddr_q;
   assign prwd10      = prwd_q;
   assign pwdata10    = pwdata_q;
   assign psel10      = psel_q;
   assign penable10   = penable_q;
   assign dbg_state10 = state_q;

endmodule

// File: tb/tb_apb_rr_master10.sv
// Bench for apb_rr_master10: directed and random transfers against a small APB slave model,
// with a scoreboard of expected completions compared whenever a done pulse appears.
module tb_apb_rr_master10;

   localparam int TO = 16;
   localparam int W  = 115;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  req = 2'b00;
   logic [63:0] addr = '0;
   logic [1:0]  wr = 2'b00;
   logic [63:0] wdata = '0;
   logic [1:0]  done;
   logic [31:0] rdata;
   logic        err;
   logic [31:0] paddr;
   logic        prwd;
   logic [31:0] pwdata;
   logic [15:0] psel;
   logic        penable;
   logic        pready = 1'b0;
   logic [31:0] prdata = '0;
   logic        pslverr = 1'b0;
   logic [1:0]  dbg_state;

   int vectors = 0;
   int miscompares = 0;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] e;
   logic [31:0]  model_rdata = '0;

   int          slv_waits = 0;
   logic [31:0] slv_rdata = '0;
   logic        slv_err = 1'b0;
   int          wcnt = 0;
   logic [31:0] obs_pa = '0, obs_pw = '0;
   logic        obs_w = 1'b0;
   logic [15:0] obs_ps = '0;

   apb_rr_master10 #(.PADDR_WIDTH10(32), .PWDATA_WIDTH10(32), .PRDATA_WIDTH10(32),
                     .TIMEOUT10(TO)) dut (
      .pclock10(clk), .preset10(rst_n), .req10(req), .addr10(addr), .write10(wr),
      .wdata10(wdata), .done10(done), .rdata10(rdata), .err10(err), .paddr10(paddr),
      .prwd10(prwd), .pwdata10(pwdata), .psel10(psel), .penable10(penable),
      .pready10(pready), .prdata10(prdata), .pslverr10(pslverr), .dbg_state10(dbg_state)
   );

   // Clock and watchdog
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] pack_exp(input logic idx, input logic er,
                                              input logic [31:0] rd, input logic [31:0] pa,
                                              input logic [31:0] pw, input logic w,
                                              input logic [15:0] ps);
      return {idx, er, rd, pa, pw, w, ps};
   endfunction

   // APB slave: drives junk on pready/pslverr/prdata outside ACCESS, which must be ignored.
   always @(negedge clk) begin
      if (psel != 16'h0000 && penable) begin
         obs_pa = paddr;
         obs_pw = pwdata;
         obs_w  = prwd;
         obs_ps = psel;
         if (wcnt < slv_waits) begin
            pready  = 1'b0;
            pslverr = 1'($urandom_range(0, 1));
            prdata  = $urandom;
            wcnt++;
         end else begin
            pready  = 1'b1;
            pslverr = slv_err;
            prdata  = slv_rdata;
         end
      end else begin
         wcnt    = 0;
         pready  = 1'b1;
         pslverr = 1'b1;
         prdata  = $urandom;
      end
   end

   // Scoreboard: every done pulse pops one expected completion
   always @(negedge clk) begin
      if (rst_n && done != 2'b00) begin
         check("done_onehot", $countones(done), 1);
         if (exp_q.size() == 0) begin
            check("sb_unexpected_done", done, 0);
         end else begin
            e = exp_q.pop_front();
            check("sb_done", done, 2'b01 << e[114]);
            check("sb_err", err, e[113]);
            check("sb_rdata", rdata, e[112:81]);
            check("sb_paddr", obs_pa, e[80:49]);
            check("sb_pwdata", obs_pw, e[48:17]);
            check("sb_prwd", obs_w, e[16]);
            check("sb_psel", obs_ps, e[15:0]);
         end
      end
   end

   task automatic run_xfer(input int idx, input logic [31:0] a, input logic w,
                           input logic [31:0] wd, input int waits, input logic [31:0] rd,
                           input logic serr, input string tag);
      logic timeout;
      logic e_err;
      int   exp_cyc;
      int   cyc;
      @(negedge clk);
      timeout = (waits >= TO);
      e_err   = timeout ? 1'b1 : serr;
      if (!timeout && !w) model_rdata = rd;
      exp_cyc = timeout ? TO + 2 : waits + 3;
      slv_waits = waits;
      slv_rdata = rd;
      slv_err   = serr;
      exp_q.push_back(pack_exp(1'(idx), e_err, model_rdata, a, wd, w, 16'(1) << a[15:12]));
      req[idx] = 1'b1;
      wr[idx]  = w;
      addr[idx*32 +: 32]  = a;
      wdata[idx*32 +: 32] = wd;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!done[idx] && cyc < 200);
      check({tag, "_latency"}, cyc, exp_cyc);
      req[idx] = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_done"}, done, 0);
      check({tag, "_psel"}, psel, 0);
      check({tag, "_penable"}, penable, 0);
      check({tag, "_paddr"}, paddr, 0);
      check({tag, "_pwdata"}, pwdata, 0);
      check({tag, "_prwd"}, prwd, 0);
      check({tag, "_rdata"}, rdata, 0);
      check({tag, "_err"}, err, 0);
      check({tag, "_state"}, dbg_state, 0);
   endtask

   initial begin
      logic [31:0] ra[2][2];
      logic [31:0] rw[2][2];
      int          cnt[2];
      int          cyc;
      logic [31:0] a;

      // Reset
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;

      // Simultaneous requests straight after reset: grants 0,1,0,1
      ra[0][0] = 32'h0000_3000; ra[0][1] = 32'h0000_5008;
      ra[1][0] = 32'h0000_8010; ra[1][1] = 32'h0000_C01C;
      for (int i = 0; i < 2; i++)
         for (int k = 0; k < 2; k++) rw[i][k] = $urandom;
      slv_waits = 0;
      slv_err   = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 2; k++)
         for (int i = 0; i < 2; i++)
            exp_q.push_back(pack_exp(1'(i), 1'b0, model_rdata, ra[i][k], rw[i][k], 1'b1,
                                     16'(1) << ra[i][k][15:12]));
      for (int i = 0; i < 2; i++) begin
         addr[i*32 +: 32]  = ra[i][0];
         wdata[i*32 +: 32] = rw[i][0];
         cnt[i] = 0;
      end
      wr  = 2'b11;
      req = 2'b11;
      cyc = 0;
      while ((cnt[0] < 2 || cnt[1] < 2) && cyc < 60) begin
         @(negedge clk);
         cyc++;
         for (int i = 0; i < 2; i++) begin
            if (done[i]) begin
               cnt[i]++;
               if (cnt[i] < 2) begin
                  addr[i*32 +: 32]  = ra[i][1];
                  wdata[i*32 +: 32] = rw[i][1];
               end else begin
                  req[i] = 1'b0;
               end
            end
         end
      end
      check("rr_count0", cnt[0], 2);
      check("rr_count1", cnt[1], 2);
      check("rr_cycles", cyc, 12);

      // Single write with cycle-exact bus checks; req drops and inputs change after the grant
      @(negedge clk);
      slv_waits = 0;
      slv_err   = 1'b0;
      exp_q.push_back(pack_exp(1'b0, 1'b0, model_rdata, 32'h0000_2004, 32'hA5A5_A5A5, 1'b1,
                               16'h0004));
      req = 2'b01;
      wr  = 2'b01;
      addr[31:0]  = 32'h0000_2004;
      wdata[31:0] = 32'hA5A5_A5A5;
      @(negedge clk);
      check("wr_c1_psel", psel, 16'h0004);
      check("wr_c1_penable", penable, 0);
      check("wr_c1_state", dbg_state, 1);
      req = 2'b00;
      wr  = 2'b00;
      addr[31:0]  = 32'hFFFF_F000;
      wdata[31:0] = 32'h0;
      @(negedge clk);
      check("wr_c2_psel", psel, 16'h0004);
      check("wr_c2_penable", penable, 1);
      check("wr_c2_paddr", paddr, 32'h0000_2004);
      check("wr_c2_pwdata", pwdata, 32'hA5A5_A5A5);
      check("wr_c2_prwd", prwd, 1);
      @(negedge clk);
      check("wr_c3_done", done, 2'b01);
      check("wr_c3_err", err, 0);
      check("wr_c3_psel", psel, 0);
      check("wr_c3_penable", penable, 0);

      // Reads with wait states, slave errors, timeout and the last-wait boundary
      run_xfer(0, 32'h0000_7100, 1'b0, 32'h0, 3, 32'h1234_5678, 1'b0, "rd_wait3");
      check("rd_wait3_rdata", rdata, 32'h1234_5678);
      run_xfer(1, 32'h0000_F0F0, 1'b1, $urandom, 0, $urandom, 1'b1, "wr_slverr");
      check("wr_slverr_err", err, 1);
      run_xfer(0, 32'h0000_A000, 1'b0, 32'h0, 1, 32'hDEAD_BEEF, 1'b1, "rd_slverr");
      run_xfer(1, 32'h0000_4444, 1'b0, 32'h0, 1000, 32'h5555_AAAA, 1'b0, "timeout");
      check("timeout_err", err, 1);
      check("timeout_rdata", rdata, 32'hDEAD_BEEF);
      check("timeout_psel", psel, 0);
      check("timeout_state", dbg_state, 0);
      run_xfer(0, 32'h0000_1ABC, 1'b0, 32'h0, TO - 1, 32'h0F0F_0F0F, 1'b0, "wait15");

      // Random single-requester transfers
      for (int n = 0; n < 8; n++) begin
         a = {16'h0, 4'($urandom_range(0, 15)), 12'($urandom)};
         run_xfer($urandom_range(0, 1), a, 1'($urandom_range(0, 1)), $urandom,
                  $urandom_range(0, 5), $urandom, 1'($urandom_range(0, 1)), "rand");
      end

      // Reset in the middle of ACCESS; requester 0 was granted last before it
      @(negedge clk);
      slv_waits = 50;
      req = 2'b01;
      wr  = 2'b01;
      addr[31:0] = 32'h0000_6000;
      repeat (3) @(negedge clk);
      check("mid_state_access", dbg_state, 2);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("mid_reset");
      req = 2'b00;
      model_rdata = '0;
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      slv_waits = 0;
      slv_err   = 1'b0;
      addr  = {32'h0000_9000, 32'h0000_B000};
      wdata = {32'h1111_2222, 32'h3333_4444};
      wr    = 2'b11;
      exp_q.push_back(pack_exp(1'b0, 1'b0, 32'h0, 32'h0000_B000, 32'h3333_4444, 1'b1, 16'h0800));
      exp_q.push_back(pack_exp(1'b1, 1'b0, 32'h0, 32'h0000_9000, 32'h1111_2222, 1'b1, 16'h0200));
      req = 2'b11;
      cyc = 0;
      while (req != 2'b00 && cyc < 40) begin
         @(negedge clk);
         cyc++;
         req = req & ~done;
      end
      check("post_reset_cycles", cyc, 6);

      @(negedge clk);
      check("sb_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/apb_rr_master10.md
APB_RR_MASTER10 -- requirements
Module: apb_rr_master10

Interface
Parameters:
REQ-001 The block SHALL have parameter PADDR_WIDTH10, default 32, meaning APB address width.
REQ-002 The block SHALL have parameter PWDATA_WIDTH10, default 32, meaning APB write data width.
REQ-003 The block SHALL have parameter PRDATA_WIDTH10, default 32, meaning APB read data width.
REQ-004 The block SHALL have parameter TIMEOUT10, default 16, meaning the maximum number of ACCESS cycles allowed before a transfer is aborted (range 2-255).

Ports:
REQ-005 The block SHALL have one clock and one asynchronous, active-low reset, with the following ports:
- pclock10  in  1  clock; all state changes on the rising edge.
- preset10  in  1  asynchronous, active-low reset.
- req10  in  2  per-requester transfer request; bit i belongs to requester i.
- addr10  in  2*PADDR_WIDTH10  per-requester address; slice i belongs to requester i.
- write10  in  2  per-requester direction; 1 means write.
- wdata10  in  2*PWDATA_WIDTH10  per-requester write data.
- done10  out  2  one-cycle completion pulse per requester.
- rdata10  out  PRDATA_WIDTH10  read data; valid when any done10 bit is high.
- err10  out  1  error flag; valid when any done10 bit is high.
- paddr10  out  PADDR_WIDTH10  APB address.
- prwd10  out  1  APB direction.
- pwdata10  out  PWDATA_WIDTH10  APB write data.
- psel10  out  16  APB one-hot slave select.
- penable10  out  1  APB enable.
- pready10  in  1  APB slave ready.
- prdata10  in  PRDATA_WIDTH10  APB read data.
- pslverr10  in  1  APB slave error.

Function
REQ-006 The block SHALL implement an FSM with the states IDLE, SETUP and ACCESS.
REQ-007 In IDLE, the block SHALL mask req10[i] whenever done10[i] is high, and then arbitrate among the remaining requests.
REQ-008 Arbitration SHALL be round-robin: on a tie, the requester not granted last wins; after reset, requester 0 has priority.
REQ-009 On a grant in IDLE, the block SHALL do the following on the same edge:
- register the granted index;
- register addr, write and wdata onto paddr10, prwd10 and pwdata10;
- set psel10 to one-hot of addr[15:12];
- enter SETUP.
REQ-010 In SETUP, psel10 SHALL be held, penable10 SHALL be 0, and the next state SHALL be ACCESS unconditionally.
REQ-011 In ACCESS, penable10 SHALL be 1, and paddr10, prwd10, pwdata10 and psel10 SHALL be held stable.
REQ-012 In ACCESS with pready10=1, the block SHALL do the following on the next edge:
- clear psel10 and penable10;
- capture prdata10 to rdata10 (reads only; otherwise rdata10 holds);
- set err10 to pslverr10;
- pulse done10[granted] for one cycle;
- return to IDLE.
REQ-013 Minimum latency SHALL be as follows: req10 high in IDLE at cycle 0, SETUP at cycle 1, ACCESS at cycle 2 with pready10=1, done10 at cycle 3.
REQ-014 In IDLE, done10 and penable10 SHALL be 0 except for the one-cycle done10 pulse; psel10 SHALL be 0.
REQ-015 An 8-bit wait counter SHALL clear on entry to ACCESS and increment each ACCESS cycle with pready10=0.
REQ-016 When the wait counter reaches TIMEOUT10-1 with pready10=0, the block SHALL end the transfer as in REQ-012, with err10=1 and rdata10 unchanged.
REQ-017 pready10 SHALL be ignored outside ACCESS, and pslverr10 SHALL be sampled only when pready10=1 in ACCESS.
REQ-018 Requesters SHALL hold req, addr, write and wdata stable until done; changes after the grant SHALL have no effect on the bus.
REQ-019 Deassertion of req10 by a requester during SETUP or ACCESS SHALL NOT abort the transfer; done10 SHALL still pulse.
REQ-020 Only one done10 bit SHALL ever be high in any cycle.

Reset
REQ-021 Asserting preset10=0 SHALL immediately clear all outputs to 0 and force IDLE, including in the middle of a transfer.
REQ-022 Reset SHALL also clear the round-robin pointer (requester 0 has priority) and the wait counter.
REQ-023 After preset10 returns to 1, the first arbitration SHALL occur on the first rising edge with a non-masked req10.

Verification
REQ-024 The bench SHALL cover a single write: req10=01, addr0=0x0000_2004, wdata0=0xA5A5_A5A5, write0=1, pready10=1. Required response: psel10=0x0004 in cycles 1-2, penable10=1 in cycle 2, done10=01 in cycle 3, err10=0.
REQ-025 The bench SHALL cover a simultaneous request after reset: req10=11, with each requester holding req until its done. Required response: grant order 0, 1, 0, 1; done10 alternates 01, 10, 01, 10.
REQ-026 The bench SHALL cover a read with wait states: pready10 low for 3 ACCESS cycles, then high with prdata10=0x1234_5678. Required response: done10 at cycle 6 from req, rdata10=0x1234_5678, err10=0.
REQ-027 The bench SHALL cover a slave error: pslverr10=1 with pready10=1. Required response: err10=1 coincident with the done10 pulse.
REQ-028 The bench SHALL cover a timeout: pready10 held 0 with TIMEOUT10=16. Required response: done10 with err10=1 after 16 ACCESS cycles, then psel10=0 and the block back in IDLE.
REQ-029 The bench SHALL cover reset mid-ACCESS: preset10=0 asynchronously. Required response: psel10, penable10 and done10 go to 0 immediately; the next request after release is granted to requester 0 first.
